// File: rtl/cordic_gain_compensator_pkg.sv
// Shared constants and types for the CORDIC gain compensation stage.
// Holds the mode encodings, the 1/K constant and the local FSM state encoding.
package cordic_gain_compensator_pkg;

    localparam int CORDIC_WIDTH  = 32;
    localparam int CORDIC_MODE_W = 2;

    // 1/K = 0.6072529349 as unsigned Q0.32
    localparam logic [31:0] CORDIC_INV_GAIN = 32'h9B74EDA8;

    localparam logic [CORDIC_MODE_W-1:0] MODE_CIRCULAR   = 2'd0;
    localparam logic [CORDIC_MODE_W-1:0] MODE_LINEAR     = 2'd1;
    localparam logic [CORDIC_MODE_W-1:0] MODE_HYPERBOLIC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cordic_gain_compensator_seq_const_multiplier.sv
// Unsigned WIDTH x WIDTH shift-add multiplier by a constant, one constant bit per clock.
// `product` shows the accumulator value including the current step, so it is final while `done` is high.
module seq_const_multiplier #(
    parameter int                WIDTH = 32,
    parameter logic [WIDTH-1:0]  CONST = 32'h9B74EDA8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   mcand_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] term;
    logic [CW-1:0]      cnt_reg;
    logic               busy_reg;

    always_comb begin
        term = '0;
        if (CONST[cnt_reg]) begin
            term = {{WIDTH{1'b0}}, mcand_reg} << cnt_reg;
        end
        acc_next = acc_reg + term;
    end

    assign busy    = busy_reg;
    assign done    = busy_reg && (cnt_reg == CW'(WIDTH - 1));
    assign product = acc_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcand_reg <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
        end else if (start) begin
            mcand_reg <= multiplicand;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
        end else if (busy_reg) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + CW'(1);
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cordic_gain_compensator.sv
// Removes the CORDIC gain from x in circular mode (x * 1/K, rounded on magnitude);
// other modes pass through. One sample in flight, valid/ready on both sides.
module cordic_gain_compensator
    import cordic_gain_compensator_pkg::*;
#(
    parameter int               WIDTH    = CORDIC_WIDTH,
    parameter logic [WIDTH-1:0] INV_GAIN = CORDIC_INV_GAIN,
    parameter int               MODE_W   = CORDIC_MODE_W
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [MODE_W-1:0]        in_mode,
    input  logic signed [WIDTH-1:0]  in_x,
    input  logic signed [WIDTH-1:0]  in_y,
    input  logic signed [WIDTH-1:0]  in_angle,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [WIDTH-1:0]  out_x,
    output logic signed [WIDTH-1:0]  out_y,
    output logic signed [WIDTH-1:0]  out_angle
);

    localparam logic [2*WIDTH-1:0] HALF_LSB = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    state_t state_reg;
    state_t state_next;

    logic [WIDTH-1:0]   out_x_reg;
    logic [WIDTH-1:0]   out_y_reg;
    logic [WIDTH-1:0]   out_angle_reg;
    logic               neg_reg;

    logic               accept;
    logic               is_circular;
    logic [WIDTH-1:0]   mag;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [2*WIDTH-1:0] rounded;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   corrected;

    assign is_circular = (in_mode == MODE_W'(MODE_CIRCULAR));
    assign accept      = (state_reg == ST_IDLE) && in_valid;
    assign mul_start   = accept && is_circular;

    // Two's complement negate in WIDTH unsigned bits: the most negative input maps to 2^(WIDTH-1).
    assign mag = in_x[WIDTH-1] ? -in_x : in_x;

    seq_const_multiplier #(
        .WIDTH (WIDTH),
        .CONST (INV_GAIN)
    ) u_mul (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (mul_start),
        .multiplicand (mag),
        .busy         (mul_busy),
        .done         (mul_done),
        .product      (mul_product)
    );

    // Round half up on the magnitude, then restore the sign; a zero magnitude stays zero.
    assign rounded   = mul_product + HALF_LSB;
    assign r_mag     = rounded[2*WIDTH-1:WIDTH];
    assign corrected = neg_reg ? -r_mag : r_mag;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid) state_next = is_circular ? ST_MUL : ST_DONE;
            ST_MUL:  if (mul_done) state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == ST_IDLE) && !mul_busy;
        out_valid = (state_reg == ST_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_x_reg     <= '0;
            out_y_reg     <= '0;
            out_angle_reg <= '0;
            neg_reg       <= 1'b0;
        end else if (accept) begin
            out_y_reg     <= in_y;
            out_angle_reg <= in_angle;
            neg_reg       <= in_x[WIDTH-1];
            if (!is_circular) begin
                out_x_reg <= in_x;
            end
        end else if ((state_reg == ST_MUL) && mul_done) begin
            out_x_reg <= corrected;
        end
    end

    assign out_x     = out_x_reg;
    assign out_y     = out_y_reg;
    assign out_angle = out_angle_reg;

endmodule
